lsu_mem_stage: RTL

- Load/store stage of the CPU; sits directly upstream of the byte-addressed data SRAM.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Drives the SRAM write-enable, address and write-data; captures the SRAM's combinational read data.
- Returns a registered, sign/zero-extended response to writeback over a second valid/ready handshake.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_mem_stage_load_extend.sv | 32 +++
 rtl/lsu_mem_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store memory stage:
//   - RV32 funct3 size/sign encodings used by loads and stores
//   - FSM state encoding for lsu_mem_stage
//   - size_to_wen    : funct3 -> SRAM byte write mask (0001 / 0011 / 1111)
//   - size_to_nbytes : funct3 -> access size in bytes (1 / 2 / 4)
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Byte-lane mask for an access of the given size, LSB-aligned.
    // Unsigned codes map to the same width; illegal codes give no lanes.
    function automatic logic [3:0] size_to_wen(input logic [2:0] funct3);
        logic [3:0] wen;
        case (funct3)
            F3_B, F3_BU: wen = 4'b0001;
            F3_H, F3_HU: wen = 4'b0011;
            F3_W:        wen = 4'b1111;
            default:     wen = 4'b0000;
        endcase
        return wen;
    endfunction

    // Number of bytes touched by the access. Illegal codes return 1 so the
    // range check stays well defined; they fault on funct3 anyway.
    function automatic logic [2:0] size_to_nbytes(input logic [2:0] funct3);
        logic [2:0] nb;
        case (funct3)
            F3_B, F3_BU: nb = 3'd1;
            F3_H, F3_HU: nb = 3'd2;
            F3_W:        nb = 3'd4;
            default:     nb = 3'd1;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of raw SRAM read data for a load.
// Ports:
//   funct3   in  3     load size/sign code (B, H, W, BU, HU)
//   raw_data in  XLEN  SRAM read data, LSB-aligned
//   ext_data out XLEN  extended result (0 for illegal codes)
// -----------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] ext_data
);

    // Select the extension for the requested load size.
    always_comb begin
        ext_data = {XLEN{1'b0}};
        case (funct3)
            F3_B:    ext_data = {{(XLEN-8){raw_data[7]}}, raw_data[7:0]};
            F3_BU:   ext_data = {{(XLEN-8){1'b0}}, raw_data[7:0]};
            F3_H:    ext_data = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
            F3_HU:   ext_data = {{(XLEN-16){1'b0}}, raw_data[15:0]};
            F3_W:    ext_data = raw_data;
            default: ext_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store stage in front of a byte-addressed data SRAM. Takes one request
// at a time from execute, performs a single-cycle SRAM access and returns a
// registered, extended response to writeback.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake from execute
//   req_we, req_funct3         store flag and RV32 size/sign code
//   req_addr, req_wdata        byte address, LSB-aligned store data
//   req_rd                     destination tag, echoed on rsp_rd
//   rsp_valid/rsp_ready        response handshake to writeback
//   rsp_rdata, rsp_rd, rsp_err extended load data, tag, access fault
//   sram_w_en                  byte write mask (nonzero only in ACCESS)
//   sram_address               SRAM byte address (held between accesses)
//   sram_write_data            SRAM write data (held between accesses)
//   sram_read_data             SRAM combinational read data
// -----------------------------------------------------------------------------
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int SRAM_AW = 16,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    input  logic [4:0]         req_rd,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_rdata,
    output logic [4:0]         rsp_rd,
    output logic               rsp_err,
    output logic [3:0]         sram_w_en,
    output logic [SRAM_AW-1:0] sram_address,
    output logic [XLEN-1:0]    sram_write_data,
    input  logic [XLEN-1:0]    sram_read_data
);

    lsu_state_e      state_r;
    logic            we_r;
    logic [2:0]      funct3_r;
    logic [4:0]      rd_r;

    logic            accept_s;
    logic            bad_f3_s;
    logic            bad_store_s;
    logic            hi_nz_s;
    logic            wrap_s;
    logic            fault_s;
    logic [2:0]      nbytes_s;
    logic [SRAM_AW:0] end_addr_s;
    logic [XLEN-1:0] ext_data_s;

    // Ready while idle, or while the held response is being consumed this
    // cycle; this keeps a combinational path from rsp_ready to req_ready so
    // back-to-back requests need no bubble.
    assign req_ready = (state_r == IDLE) || ((state_r == RESP) && rsp_ready);
    assign accept_s  = req_valid && req_ready;

    // Fault classification of the incoming request.
    always_comb begin
        bad_f3_s = 1'b1;
        case (req_funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_f3_s = 1'b0;
            default:                        bad_f3_s = 1'b1;
        endcase
        bad_store_s = req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU));
        hi_nz_s     = |req_addr[XLEN-1:SRAM_AW];
        nbytes_s    = size_to_nbytes(req_funct3);
        // Last byte address computed one bit wider: a carry into the top bit
        // means the access would wrap past the end of the SRAM.
        end_addr_s  = {1'b0, req_addr[SRAM_AW-1:0]}
                    + {{(SRAM_AW-2){1'b0}}, nbytes_s}
                    - {{SRAM_AW{1'b0}}, 1'b1};
        wrap_s      = end_addr_s[SRAM_AW];
        fault_s     = bad_f3_s || bad_store_s || hi_nz_s || wrap_s;
    end

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3   (funct3_r),
        .raw_data (sram_read_data),
        .ext_data (ext_data_s)
    );

    // Request/response FSM with all SRAM-side and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            we_r            <= 1'b0;
            funct3_r        <= 3'b000;
            rd_r            <= 5'd0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= {XLEN{1'b0}};
            rsp_rd          <= 5'd0;
            rsp_err         <= 1'b0;
            sram_w_en       <= 4'b0000;
            sram_address    <= {SRAM_AW{1'b0}};
            sram_write_data <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ACCESS: begin
                    // Store commits in the SRAM on this edge; loads capture here.
                    sram_w_en <= 4'b0000;
                    rsp_rdata <= we_r ? {XLEN{1'b0}} : ext_data_s;
                    rsp_rd    <= rd_r;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                IDLE, RESP: begin
                    if (accept_s) begin
                        we_r     <= req_we;
                        funct3_r <= req_funct3;
                        rd_r     <= req_rd;
                        if (fault_s) begin
                            // Faulting requests never reach the SRAM; the
                            // address/data lines keep their previous values.
                            sram_w_en <= 4'b0000;
                            rsp_rdata <= {XLEN{1'b0}};
                            rsp_rd    <= req_rd;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state_r   <= RESP;
                        end else begin
                            sram_w_en       <= req_we ? size_to_wen(req_funct3) : 4'b0000;
                            sram_address    <= req_addr[SRAM_AW-1:0];
                            sram_write_data <= req_wdata;
                            rsp_err         <= 1'b0;
                            rsp_valid       <= 1'b0;
                            state_r         <= ACCESS;
                        end
                    end else if ((state_r == RESP) && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        sram_w_en <= 4'b0000;
                        state_r   <= IDLE;
                    end else begin
                        // Hold the response (or stay idle) until consumed.
                        sram_w_en <= 4'b0000;
                        state_r   <= state_r;
                    end
                end
                default: begin
                    sram_w_en <= 4'b0000;
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
